rv32_csr_unit: RTL

- Parametrised machine-mode CSR file for the RV32I core. It replaces the fixed-function CSR block.
- Adds real 64-bit mcycle/minstret counters with mcountinhibit, a configurable number of platform interrupt lines, and a fixed-priority interrupt arbiter.
- Computes the trap target, with optional vectored mtvec mode.
- Sits beside the execute stage: decode drives the CSR access port; the trap controller drives the trap/mret port and consumes irq_req/irq_cause.

---
 rtl/rv32_csr_unit_if.sv | 31 +++
 rtl/rv32_csr_unit.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/rv32_csr_unit_if.sv
// CSR access and trap/return port between decode/trap controller and the CSR file.
interface rv32_csr_unit_if;
    logic [11:0] csr_addr;
    logic [2:0]  csr_op;
    logic [31:0] csr_wdata;
    logic        csr_we;
    logic [31:0] csr_rdata;
    logic        csr_illegal;
    logic        trap_take;
    logic        trap_is_irq;
    logic [4:0]  trap_cause;
    logic [31:0] trap_pc;
    logic [31:0] trap_val;
    logic        mret;
    logic        irq_req;
    logic [4:0]  irq_cause;
    logic [31:0] trap_vector;
    logic [31:0] mepc_out;

    modport master (
        output csr_addr, csr_op, csr_wdata, csr_we,
        output trap_take, trap_is_irq, trap_cause, trap_pc, trap_val, mret,
        input  csr_rdata, csr_illegal, irq_req, irq_cause, trap_vector, mepc_out
    );

    modport slave (
        input  csr_addr, csr_op, csr_wdata, csr_we,
        input  trap_take, trap_is_irq, trap_cause, trap_pc, trap_val, mret,
        output csr_rdata, csr_illegal, irq_req, irq_cause, trap_vector, mepc_out
    );
endinterface

// File: rtl/rv32_csr_unit.sv
// Machine-mode CSR file: 64-bit counters, interrupt arbiter, trap entry/return.
// Define RV32_CSR_VECTORED_EN to make mtvec.MODE writable and enable vectored targets.
module rv32_csr_unit #(
    parameter int          NUM_EXT_IRQ = 4,
    parameter int          ADDR_WIDTH  = 24,
    parameter logic [31:0] HART_ID     = 32'd0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    rv32_csr_unit_if.slave         bus,
    input  logic                   instret_inc_i,
    input  logic [63:0]            mtime_i,
    input  logic                   irq_soft_i,
    input  logic                   irq_timer_i,
    input  logic [NUM_EXT_IRQ-1:0] irq_ext_i
);
    localparam logic [63:0] AMASK64   = (64'd1 << ADDR_WIDTH) - 64'd1;
    localparam logic [31:0] AMASK     = AMASK64[31:0];
    localparam logic [63:0] EXT64     = ((64'd1 << NUM_EXT_IRQ) - 64'd1) << 16;
    localparam logic [31:0] MIE_MASK  = EXT64[31:0] | 32'h0000_0888;
    localparam logic [31:0] MEPC_MASK = AMASK & 32'hFFFF_FFFC;
`ifdef RV32_CSR_VECTORED_EN
    localparam logic [31:0] MTVEC_MASK = AMASK & 32'hFFFF_FFFD;
`else
    localparam logic [31:0] MTVEC_MASK = AMASK & 32'hFFFF_FFFC;
`endif

    logic        mst_mie_q, mst_mie_d;
    logic        mst_mpie_q, mst_mpie_d;
    logic [31:0] mie_q, mtvec_q, mscratch_q, mepc_q, mcause_q, mtval_q, mip_q, mip_d;
    logic        cy_inh_q, ir_inh_q;
    logic [63:0] mcycle_q, mcycle_d, minstret_q, minstret_d;

    logic [31:0] rdata, wval, mstatus_rd, pend;
    logic        known, ro, wr_ok;
    logic [4:0]  cause;

    assign mstatus_rd = {19'd0, 2'b11, 3'd0, mst_mpie_q, 3'd0, mst_mie_q, 3'd0};

    always_comb begin
        rdata = 32'd0;
        known = 1'b1;
        ro    = 1'b0;
        case (bus.csr_addr)
            12'h300: rdata = mstatus_rd;
            12'h301: rdata = 32'h4000_0100;
            12'h304: rdata = mie_q;
            12'h305: rdata = mtvec_q;
            12'h320: rdata = {29'd0, ir_inh_q, 1'b0, cy_inh_q};
            12'h340: rdata = mscratch_q;
            12'h341: rdata = mepc_q;
            12'h342: rdata = mcause_q;
            12'h343: rdata = mtval_q;
            12'h344: rdata = mip_q;
            12'hB00: rdata = mcycle_q[31:0];
            12'hB80: rdata = mcycle_q[63:32];
            12'hB02: rdata = minstret_q[31:0];
            12'hB82: rdata = minstret_q[63:32];
            12'hC00: begin rdata = mcycle_q[31:0];    ro = 1'b1; end
            12'hC80: begin rdata = mcycle_q[63:32];   ro = 1'b1; end
            12'hC01: begin rdata = mtime_i[31:0];     ro = 1'b1; end
            12'hC81: begin rdata = mtime_i[63:32];    ro = 1'b1; end
            12'hC02: begin rdata = minstret_q[31:0];  ro = 1'b1; end
            12'hC82: begin rdata = minstret_q[63:32]; ro = 1'b1; end
            12'hF11, 12'hF12, 12'hF13: ro = 1'b1;
            12'hF14: begin rdata = HART_ID; ro = 1'b1; end
            default: known = 1'b0;
        endcase
    end

    assign bus.csr_rdata   = rdata;
    assign bus.csr_illegal = ~known | (bus.csr_we & ro);

    // Read-modify-write is built on the masked read value; the field mask is applied at the flop.
    always_comb begin
        case (bus.csr_op[1:0])
            2'b01:   wval = bus.csr_wdata;
            2'b10:   wval = rdata | bus.csr_wdata;
            2'b11:   wval = rdata & ~bus.csr_wdata;
            default: wval = rdata;
        endcase
    end

    // A taken trap flushes the pipeline, so its CSR write never lands.
    assign wr_ok = bus.csr_we & known & ~ro & ~bus.trap_take & (bus.csr_op[1:0] != 2'b00);

    always_comb begin
        mip_d                   = 32'd0;
        mip_d[3]                = irq_soft_i;
        mip_d[7]                = irq_timer_i;
        mip_d[11]               = |irq_ext_i;
        mip_d[16 +: NUM_EXT_IRQ] = irq_ext_i;
    end

    // A write to one half loads that half only; the other half holds with no carry.
    always_comb begin
        mcycle_d = mcycle_q;
        if (wr_ok && bus.csr_addr == 12'hB00)      mcycle_d[31:0]  = wval;
        else if (wr_ok && bus.csr_addr == 12'hB80) mcycle_d[63:32] = wval;
        else if (!cy_inh_q)                        mcycle_d        = mcycle_q + 64'd1;

        minstret_d = minstret_q;
        if (wr_ok && bus.csr_addr == 12'hB02)      minstret_d[31:0]  = wval;
        else if (wr_ok && bus.csr_addr == 12'hB82) minstret_d[63:32] = wval;
        else if (instret_inc_i && !ir_inh_q)       minstret_d        = minstret_q + 64'd1;
    end

    always_comb begin
        mst_mie_d  = mst_mie_q;
        mst_mpie_d = mst_mpie_q;
        if (bus.trap_take) begin
            mst_mpie_d = mst_mie_q;
            mst_mie_d  = 1'b0;
        end else begin
            if (wr_ok && bus.csr_addr == 12'h300) begin
                mst_mie_d  = wval[3];
                mst_mpie_d = wval[7];
            end
            if (bus.mret) begin
                mst_mie_d  = mst_mpie_q;
                mst_mpie_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mst_mie_q  <= 1'b0;
            mst_mpie_q <= 1'b0;
            mie_q      <= 32'd0;
            mtvec_q    <= 32'd0;
            mscratch_q <= 32'd0;
            mepc_q     <= 32'd0;
            mcause_q   <= 32'd0;
            mtval_q    <= 32'd0;
            mip_q      <= 32'd0;
            cy_inh_q   <= 1'b0;
            ir_inh_q   <= 1'b0;
            mcycle_q   <= 64'd0;
            minstret_q <= 64'd0;
        end else begin
            mst_mie_q  <= mst_mie_d;
            mst_mpie_q <= mst_mpie_d;
            mip_q      <= mip_d;
            mcycle_q   <= mcycle_d;
            minstret_q <= minstret_d;
            if (bus.trap_take) begin
                mepc_q   <= bus.trap_pc & MEPC_MASK;
                mcause_q <= {bus.trap_is_irq, 26'd0, bus.trap_cause};
                mtval_q  <= bus.trap_val;
            end else if (wr_ok) begin
                case (bus.csr_addr)
                    12'h304: mie_q      <= wval & MIE_MASK;
                    12'h305: mtvec_q    <= wval & MTVEC_MASK;
                    12'h320: begin
                        cy_inh_q <= wval[0];
                        ir_inh_q <= wval[2];
                    end
                    12'h340: mscratch_q <= wval;
                    12'h341: mepc_q     <= wval & MEPC_MASK;
                    12'h342: mcause_q   <= wval & 32'h8000_001F;
                    12'h343: mtval_q    <= wval;
                    default: ;
                endcase
            end
        end
    end

    // Fixed priority 11 > 3 > 7 > platform lines (lowest index first); later assignments win.
    assign pend = mip_q & mie_q;

    always_comb begin
        cause = 5'd0;
        for (int i = NUM_EXT_IRQ - 1; i >= 0; i--) begin
            if (pend[16 + i]) cause = 5'(16 + i);
        end
        if (pend[7])  cause = 5'd7;
        if (pend[3])  cause = 5'd3;
        if (pend[11]) cause = 5'd11;
    end

    assign bus.irq_req   = mst_mie_q & (|pend);
    assign bus.irq_cause = cause;
    assign bus.mepc_out  = mepc_q;

`ifdef RV32_CSR_VECTORED_EN
    logic [31:0] base;
    assign base = mtvec_q & 32'hFFFF_FFFC;
    assign bus.trap_vector = (mtvec_q[0] && bus.trap_is_irq) ?
                             base + {25'd0, bus.trap_cause, 2'b00} : base;
`else
    assign bus.trap_vector = mtvec_q & 32'hFFFF_FFFC;
`endif
endmodule
